// File: rtl/ysyx_22050550_alu_pipe.sv
// Two-stage valid/ready pipeline around the external combinational ALU.
// Stage E holds an accepted op and drives the ALU. Stage W captures the
// ALU result and flags until the consumer takes them. The block also keeps
// sticky overflow/carry flags and a retired-op counter for debug.
module ysyx_22050550_alu_pipe #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   in_a,
  input  logic [LEN-1:0]   in_b,
  input  logic [2:0]       in_func,
  output logic [LEN-1:0]   alu_a,
  output logic [LEN-1:0]   alu_b,
  output logic [2:0]       alu_func,
  input  logic [LEN-1:0]   alu_out,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   out_res,
  output logic             out_overflow,
  output logic             out_carry,
  output logic             out_zero,
  output logic             sticky_ov,
  output logic             sticky_cy,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;

  logic             e_valid;
  logic [LEN-1:0]   e_a;
  logic [LEN-1:0]   e_b;
  logic [2:0]       e_func;
  logic             w_valid;
  logic [LEN-1:0]   w_res;
  logic             w_ov;
  logic             w_cy;
  logic             s_ov;
  logic             s_cy;
  logic [CNT_W-1:0] cnt;

  logic             w_adv;
  logic             accept;
  logic             out_hs;
  logic             arith;
  logic             cap_ov;
  logic             cap_cy;

  // Handshake/advance decisions; in_ready only sees out_ready combinationally.
  always_comb begin
    w_adv    = e_valid && (!w_valid || out_ready);
    in_ready = !e_valid || w_adv;
    accept   = in_valid && in_ready;
    out_hs   = w_valid && out_ready;
    arith    = (e_func == FN_ADD) || (e_func == FN_SUB);
    cap_ov   = arith && alu_overflow;
    cap_cy   = arith && alu_carry;
  end

  // E stage: load on accept, drain when the op moves into W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_func  <= '0;
    end else if (accept) begin
      e_valid <= 1'b1;
      e_a     <= in_a;
      e_b     <= in_b;
      e_func  <= in_func;
    end else if (w_adv) begin
      e_valid <= 1'b0;
    end
  end

  // W stage: capture ALU result with flags masked to add/sub, hold until taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_res   <= '0;
      w_ov    <= 1'b0;
      w_cy    <= 1'b0;
    end else if (w_adv) begin
      w_valid <= 1'b1;
      w_res   <= alu_out;
      w_ov    <= cap_ov;
      w_cy    <= cap_cy;
    end else if (out_hs) begin
      w_valid <= 1'b0;
    end
  end

  // Sticky flags: a set on W entry beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_ov <= 1'b0;
      s_cy <= 1'b0;
    end else begin
      if (w_adv && cap_ov) begin
        s_ov <= 1'b1;
      end else if (sticky_clr) begin
        s_ov <= 1'b0;
      end
      if (w_adv && cap_cy) begin
        s_cy <= 1'b1;
      end else if (sticky_clr) begin
        s_cy <= 1'b0;
      end
    end
  end

  // Retired-op counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (out_hs) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Port mapping; out_zero derives from the registered result only.
  always_comb begin
    alu_a        = e_a;
    alu_b        = e_b;
    alu_func     = e_func;
    out_valid    = w_valid;
    out_res      = w_res;
    out_overflow = w_ov;
    out_carry    = w_cy;
    out_zero     = (w_res == LEN'(0));
    sticky_ov    = s_ov;
    sticky_cy    = s_cy;
    retired      = cnt;
  end

endmodule

// File: tb/tb_ysyx_22050550_alu_pipe.sv
// Bench for ysyx_22050550_alu_pipe (LEN=4, CNT_W=4): directed scenarios
// followed by random traffic, all checked against an occupancy-level model.
module tb_ysyx_22050550_alu_pipe;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
  } op_t;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_func;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_func;
  logic [3:0] alu_out;
  logic       alu_overflow;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_res;
  logic       out_overflow;
  logic       out_carry;
  logic       out_zero;
  logic       sticky_ov;
  logic       sticky_cy;
  logic       sticky_clr;
  logic [3:0] retired;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: ops in flight in accept order, plus stage occupancy.
  op_t  q[$];
  logic m_e;
  logic m_w;
  logic m_sov;
  logic m_scy;
  int   m_cnt;

  ysyx_22050550_alu_pipe #(.LEN(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_func(in_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_overflow(out_overflow), .out_carry(out_carry),
    .out_zero(out_zero), .sticky_ov(sticky_ov), .sticky_cy(sticky_cy),
    .sticky_clr(sticky_clr), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU returning {overflow, carry, out}. Logic ops return junk
  // flags on purpose so that the pipe's flag masking is exercised.
  function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    int sa, sb, s;
    logic [3:0] r;
    logic ov, cy;
    sa = (a >= 8) ? int'(a) - 16 : int'(a);
    sb = (b >= 8) ? int'(b) - 16 : int'(b);
    ov = a[0];
    cy = b[0];
    case (f)
      3'd0: begin s = int'(a) + int'(b); r = 4'(s); cy = (s >= 16); ov = (sa + sb > 7) || (sa + sb < -8); end
      3'd1: begin s = int'(a) + (15 - int'(b)) + 1; r = 4'(s); cy = (s >= 16); ov = (sa - sb > 7) || (sa - sb < -8); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (sa < sb) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {ov, cy, r};
  endfunction

  always_comb {alu_overflow, alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_func);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] expect_w(input op_t o);
    logic [5:0] r;
    r = alu_fn(o.a, o.b, o.f);
    if (o.f > 3'd1) r[5:4] = 2'b00;
    return r;
  endfunction

  // Compare every observable output with the model (called mid-cycle).
  task automatic check_model();
    logic [5:0] r;
    chk("out_valid", 32'(out_valid), 32'(m_w));
    chk("in_ready", 32'(in_ready), 32'(!m_e || !m_w || out_ready));
    chk("sticky_ov", 32'(sticky_ov), 32'(m_sov));
    chk("sticky_cy", 32'(sticky_cy), 32'(m_scy));
    chk("retired", 32'(retired), 32'(m_cnt % 16));
    if (m_w && q.size() > 0) begin
      r = expect_w(q[0]);
      chk("out_res", 32'(out_res), 32'(r[3:0]));
      chk("out_overflow", 32'(out_overflow), 32'(r[5]));
      chk("out_carry", 32'(out_carry), 32'(r[4]));
      chk("out_zero", 32'(out_zero), 32'(r[3:0] == 4'd0));
    end
    if (m_e && q.size() > 0) begin
      chk("alu_a", 32'(alu_a), 32'(q[q.size()-1].a));
      chk("alu_b", 32'(alu_b), 32'(q[q.size()-1].b));
      chk("alu_func", 32'(alu_func), 32'(q[q.size()-1].f));
    end
  endtask

  // Drive one cycle of inputs (just after the edge) and check mid-cycle.
  task automatic cyc(input logic iv, input logic [3:0] a, input logic [3:0] b,
                     input logic [2:0] f, input logic ordy, input logic clr);
    in_valid   = iv;
    in_a       = a;
    in_b       = b;
    in_func    = f;
    out_ready  = ordy;
    sticky_clr = clr;
    @(negedge clock);
    check_model();
  endtask

  // Apply the edge to the model, then move to just after the real edge.
  task automatic adv();
    logic ir, hs, wadv, acc;
    logic [5:0] r;
    op_t o;
    ir   = !m_e || !m_w || out_ready;
    hs   = m_w && out_ready;
    wadv = m_e && (!m_w || out_ready);
    acc  = in_valid && ir;
    r    = 6'd0;
    if (wadv && q.size() > 0) r = expect_w(q[q.size()-1]);
    if (wadv && r[5]) m_sov = 1'b1; else if (sticky_clr) m_sov = 1'b0;
    if (wadv && r[4]) m_scy = 1'b1; else if (sticky_clr) m_scy = 1'b0;
    if (hs && q.size() > 0) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (acc) begin
      o.a = in_a; o.b = in_b; o.f = in_func;
      q.push_back(o);
    end
    m_w = wadv || (m_w && !out_ready);
    m_e = acc || (m_e && !wadv);
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    m_e = 1'b0; m_w = 1'b0; m_sov = 1'b0; m_scy = 1'b0; m_cnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_func = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    model_clear();

    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 1: overflowing add 0111+0001
    cyc(1'b1, 4'b0111, 4'b0001, 3'b000, 1'b1, 1'b0); adv();
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0); adv();
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_res", 32'(out_res), 32'b1000);
    chk("t1_ov", 32'(out_overflow), 32'd1);
    chk("t1_zero", 32'(out_zero), 32'd0);
    adv();
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    chk("t1_sticky", 32'(sticky_ov), 32'd1);
    adv();

    // 2: back-to-back sub, lt, eq
    cyc(1'b1, 4'b0011, 4'b0101, 3'b001, 1'b1, 1'b0); adv();
    cyc(1'b1, 4'b1000, 4'b0111, 3'b110, 1'b1, 1'b0); adv();
    cyc(1'b1, 4'b0101, 4'b0101, 3'b111, 1'b1, 1'b0);
    chk("t2_sub", 32'(out_res), 32'b1110);
    adv();
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    chk("t2_lt", 32'(out_res), 32'b0001);
    chk("t2_lt_flags", 32'({out_overflow, out_carry}), 32'd0);
    adv();
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    chk("t2_eq", 32'(out_res), 32'b0001);
    chk("t2_eq_flags", 32'({out_overflow, out_carry}), 32'd0);
    adv();

    // 3: consumer stalled while three ops are offered
    cyc(1'b1, 4'd1, 4'd2, 3'b000, 1'b0, 1'b0); adv();
    cyc(1'b1, 4'd3, 4'd4, 3'b100, 1'b0, 1'b0); adv();
    cyc(1'b1, 4'd5, 4'd6, 3'b011, 1'b0, 1'b0);
    chk("t3_stall", 32'(in_ready), 32'd0);
    adv();
    cyc(1'b1, 4'd5, 4'd6, 3'b011, 1'b1, 1'b0);
    chk("t3_release", 32'(in_ready), 32'd1);
    adv();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0); adv();
    end

    // 4: clear racing an overflow set, then a lone clear
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b1); adv();
    cyc(1'b1, 4'b0111, 4'b0111, 3'b000, 1'b1, 1'b0); adv();
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b1); adv();
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b1);
    chk("t4_set_wins", 32'(sticky_ov), 32'd1);
    adv();
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    chk("t4_cleared", 32'(sticky_ov), 32'd0);
    adv();

    // 5: asynchronous reset with E and W both full
    cyc(1'b1, 4'b0111, 4'b0111, 3'b000, 1'b0, 1'b0); adv();
    cyc(1'b1, 4'b1010, 4'b0011, 3'b101, 1'b0, 1'b0); adv();
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_retired", 32'(retired), 32'd0);
    chk("t5_sticky", 32'({sticky_ov, sticky_cy}), 32'd0);
    chk("t5_alu_a", 32'(alu_a), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0); adv();
    end

    // 6: 17 zero-result handshakes wrap the 4-bit counter to 1
    for (int i = 0; i < 19; i++) begin
      cyc(i < 17, 4'b1111, 4'b1111, 3'b101, 1'b1, 1'b0);
      if (i >= 2) chk("t6_zero", 32'(out_zero), 32'd1);
      adv();
    end
    cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);
    chk("t6_retired", 32'(retired), 32'd1);
    adv();

    // Random traffic with random back-pressure and clears
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
          ($urandom % 3) != 0, ($urandom % 8) == 0);
      adv();
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0); adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
